// File: rtl/spi_seq_pkg.sv
// Shared types, constants and helpers for the SPI transaction sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, DROP, ISSUE, GAP} seq_state_t;

  localparam int unsigned SEQ_MIN_GAP   = 2;
  localparam int unsigned SEQ_IDX_W     = 8;
  localparam int unsigned SEQ_MAX_WIDTH = 1 << SEQ_IDX_W;

  // Mask arrives left-aligned and padded with ones (write) below the real word.
  function automatic logic has_read_bits(input int unsigned length,
                                         input logic [SEQ_MAX_WIDTH-1:0] mask);
    logic rd;
    rd = 1'b0;
    for (int unsigned i = 0; i < SEQ_MAX_WIDTH; i++) begin
      if (i < length && !mask[SEQ_IDX_W'(SEQ_MAX_WIDTH - 1 - i)]) rd = 1'b1;
    end
    return rd;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags; push and pop on a full
// queue in the same cycle are both performed.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/spi_transaction_sequencer.sv
// Queues host SPI transactions, issues them to the SPI master with a minimum
// gap, and returns read data through a credited response queue.
// Optional length checking is enabled by defining SPI_SEQ_LEN_CHECK_EN.
module spi_transaction_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned TRANSACTION_LEN_WIDTH = 6,
  parameter int unsigned CMD_DEPTH             = 8,
  parameter int unsigned MAX_INFLIGHT          = 4,
  parameter int unsigned GAP_WIDTH             = 8
) (
  input  logic                             fabric_clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
  input  logic [DATA_WIDTH-1:0]            cmd_data,
  input  logic [DATA_WIDTH-1:0]            cmd_rw_mask,
  input  logic [GAP_WIDTH-1:0]             gap_cycles,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic                             spi_rd_valid,
  input  logic [DATA_WIDTH-1:0]            spi_rd_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             busy,
  output logic                             err_len,
  output logic                             err_unexp
);

  localparam int unsigned CMD_W  = 2 * DATA_WIDTH + TRANSACTION_LEN_WIDTH + 1;
  localparam int unsigned CRED_W = $clog2(MAX_INFLIGHT + 1);

  seq_state_t                       state;
  logic [CRED_W-1:0]                credits;
  logic [GAP_WIDTH-1:0]             gap_cnt;
  logic [GAP_WIDTH-1:0]             gap_load;

  logic                             cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic                             push_rd;
  logic [CMD_W-1:0]                 cmd_head;
  logic                             head_rd;
  logic [TRANSACTION_LEN_WIDTH-1:0] head_len;
  logic [DATA_WIDTH-1:0]            head_data, head_mask;
  logic                             len_illegal;

  logic                             rsp_full, rsp_empty, rsp_push, rsp_pop;
  logic                             credit_inc;
  logic [DATA_WIDTH-1:0]            rsp_head;

  // Read-bearing flag is resolved once at push time and travels with the entry.
  assign push_rd = has_read_bits(32'(cmd_length),
                                 {cmd_rw_mask, {(SEQ_MAX_WIDTH - DATA_WIDTH){1'b1}}});
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign cmd_pop   = (state == ISSUE) || (state == DROP);
  assign {head_rd, head_len, head_data, head_mask} = cmd_head;

`ifdef SPI_SEQ_LEN_CHECK_EN
  assign len_illegal = (head_len == '0) || (32'(head_len) > DATA_WIDTH);
`else
  assign len_illegal = 1'b0;
`endif

  assign gap_load = (gap_cycles < GAP_WIDTH'(SEQ_MIN_GAP)) ? GAP_WIDTH'(SEQ_MIN_GAP) : gap_cycles;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (fabric_clk),
    .reset   (reset),
    .wr_en   (cmd_push),
    .wr_data ({push_rd, cmd_length, cmd_data, cmd_rw_mask}),
    .rd_en   (cmd_pop),
    .rd_data (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty)
  );

  assign rsp_pop    = !rsp_empty && rsp_ready;
  assign rsp_push   = spi_rd_valid && (credits != '0) && !rsp_full;
  assign credit_inc = (state == ISSUE) && head_rd;
  assign rsp_valid  = !rsp_empty;
  assign rsp_data   = rsp_empty ? '0 : rsp_head;
  assign busy       = !cmd_empty || (state != IDLE) || (credits != '0);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(MAX_INFLIGHT)) u_rsp_fifo (
    .clk     (fabric_clk),
    .reset   (reset),
    .wr_en   (rsp_push),
    .wr_data (spi_rd_data),
    .rd_en   (rsp_pop),
    .rd_data (rsp_head),
    .full    (rsp_full),
    .empty   (rsp_empty)
  );

  // Issue FSM; the length strobe is loaded on entry to ISSUE so it is high exactly there.
  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      state               <= IDLE;
      gap_cnt             <= '0;
      transaction_length  <= '0;
      transaction_data    <= '0;
      transaction_rw_mask <= '0;
      err_len             <= 1'b0;
    end else begin
      transaction_length <= '0;
      case (state)
        IDLE:  if (!cmd_empty) state <= CHECK;
        CHECK: begin
          if (len_illegal) begin
            state <= DROP;
          end else if (!(head_rd && credits == CRED_W'(MAX_INFLIGHT))) begin
            state              <= ISSUE;
            transaction_length <= head_len;
            if (head_len != '0) begin
              transaction_data    <= head_data;
              transaction_rw_mask <= head_mask;
            end
          end
        end
        DROP: begin
          err_len <= 1'b1;
          state   <= IDLE;
        end
        ISSUE: begin
          gap_cnt <= gap_load;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt <= GAP_WIDTH'(1)) state <= IDLE;
          else                          gap_cnt <= gap_cnt - GAP_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Credits reserve response slots; a simultaneous take and release cancel out.
  always_ff @(posedge fabric_clk) begin
    if (reset) begin
      credits   <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (credit_inc && !rsp_pop)      credits <= credits + CRED_W'(1);
      else if (!credit_inc && rsp_pop) credits <= credits - CRED_W'(1);
      if (spi_rd_valid && credits == '0) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed self-checking bench for spi_transaction_sequencer.
`timescale 1ns/1ps
module tb_spi_transaction_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 6;
  localparam int unsigned GW = 8;

  logic          fabric_clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_length;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] cmd_rw_mask;
  logic [GW-1:0] gap_cycles;
  logic [LW-1:0] transaction_length;
  logic [DW-1:0] transaction_data;
  logic [DW-1:0] transaction_rw_mask;
  logic          spi_rd_valid;
  logic [DW-1:0] spi_rd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic          err_len;
  logic          err_unexp;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobe_cyc[$];
  logic [LW-1:0] strobe_len[$];

  spi_transaction_sequencer dut (
    .fabric_clk          (fabric_clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_length          (cmd_length),
    .cmd_data            (cmd_data),
    .cmd_rw_mask         (cmd_rw_mask),
    .gap_cycles          (gap_cycles),
    .transaction_length  (transaction_length),
    .transaction_data    (transaction_data),
    .transaction_rw_mask (transaction_rw_mask),
    .spi_rd_valid        (spi_rd_valid),
    .spi_rd_data         (spi_rd_data),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .busy                (busy),
    .err_len             (err_len),
    .err_unexp           (err_unexp)
  );

  always #5 fabric_clk = ~fabric_clk;

  // Strobe recorder: sees the value held during the cycle that just ended.
  always @(posedge fabric_clk) begin
    cyc = cyc + 1;
    if (transaction_length != '0) begin
      strobe_cyc.push_back(cyc);
      strobe_len.push_back(transaction_length);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push_cmd(input logic [LW-1:0] len, input logic [DW-1:0] d, input logic [DW-1:0] m);
    cmd_valid   = 1'b1;
    cmd_length  = len;
    cmd_data    = d;
    cmd_rw_mask = m;
    @(negedge fabric_clk);
    cmd_valid   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge fabric_clk);
    reset = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (transaction_length !== '0) begin errors++; $display("FAIL reset_len got=%0d exp=0", transaction_length); end
    checks++; if (transaction_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", transaction_data); end
    checks++; if (transaction_rw_mask !== '0) begin errors++; $display("FAIL reset_mask got=%h exp=0", transaction_rw_mask); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len got=%b exp=0", err_len); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err_unexp got=%b exp=0", err_unexp); end
  endtask

  task automatic test_write_issue;
    int base;
    logic dropped;
    base = strobe_cyc.size();
    gap_cycles = 8'd4;
    push_cmd(6'd8, 32'hA500_0000, 32'hFF00_0000);
    checks++; if (transaction_length !== '0) begin errors++; $display("FAIL wr_len_t1 got=%0d exp=0", transaction_length); end
    @(negedge fabric_clk);
    checks++; if (transaction_length !== '0) begin errors++; $display("FAIL wr_len_t2 got=%0d exp=0", transaction_length); end
    @(negedge fabric_clk);
    checks++; if (transaction_length !== 6'd8) begin errors++; $display("FAIL wr_len_t3 got=%0d exp=8", transaction_length); end
    checks++; if (transaction_data !== 32'hA500_0000) begin errors++; $display("FAIL wr_data got=%h exp=a5000000", transaction_data); end
    checks++; if (transaction_rw_mask !== 32'hFF00_0000) begin errors++; $display("FAIL wr_mask got=%h exp=ff000000", transaction_rw_mask); end
    @(negedge fabric_clk);
    checks++; if (transaction_length !== '0) begin errors++; $display("FAIL wr_len_t4 got=%0d exp=0", transaction_length); end
    checks++; if (transaction_data !== 32'hA500_0000) begin errors++; $display("FAIL wr_data_hold got=%h exp=a5000000", transaction_data); end
    repeat (3) @(negedge fabric_clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_in_gap got=%b exp=1", busy); end
    dropped = 1'b0;
    for (int i = 0; i < 10 && !dropped; i++) begin
      @(negedge fabric_clk);
      if (busy === 1'b0) dropped = 1'b1;
    end
    checks++; if (!dropped) begin errors++; $display("FAIL wr_busy_drop got=busy_stuck exp=busy_0"); end
    checks++; if (strobe_cyc.size() - base != 1) begin errors++; $display("FAIL wr_strobe_count got=%0d exp=1", strobe_cyc.size() - base); end
  endtask

  task automatic test_read_credit;
    logic seen;
    gap_cycles = 8'd2;
    push_cmd(6'd16, 32'h0, 32'hFF00_0000);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (transaction_length == 6'd16) seen = 1'b1;
      else @(negedge fabric_clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rd_strobe got=none exp=len16"); end
    repeat (10) @(negedge fabric_clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_credit_busy got=%b exp=1", busy); end
    spi_rd_valid = 1'b1;
    spi_rd_data  = 32'h0000_1234;
    @(negedge fabric_clk);
    spi_rd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 32'h0000_1234) begin errors++; $display("FAIL rd_rsp_data got=%h exp=00001234", rsp_data); end
    rsp_ready = 1'b1;
    @(negedge fabric_clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pop_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_credit_release got=%b exp=0", busy); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rd_err_unexp got=%b exp=0", err_unexp); end
  endtask

  task automatic test_credit_stall;
    int base;
    int min_space;
    logic seen;
    base = strobe_cyc.size();
    gap_cycles = 8'd2;
    for (int i = 1; i <= 5; i++) push_cmd(6'd8, DW'(i), 32'h00FF_FFFF);
    repeat (40) @(negedge fabric_clk);
    checks++; if (strobe_cyc.size() - base != 4) begin errors++; $display("FAIL stall_strobes got=%0d exp=4", strobe_cyc.size() - base); end
    checks++; if (transaction_data !== 32'd4) begin errors++; $display("FAIL stall_last_data got=%h exp=4", transaction_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b exp=1", busy); end
    spi_rd_valid = 1'b1;
    spi_rd_data  = 32'h0000_00C0;
    @(negedge fabric_clk);
    spi_rd_valid = 1'b0;
    checks++; if (rsp_data !== 32'h0000_00C0) begin errors++; $display("FAIL stall_rsp_data got=%h exp=000000c0", rsp_data); end
    repeat (3) @(negedge fabric_clk);
    checks++; if (strobe_cyc.size() - base != 4) begin errors++; $display("FAIL stall_hold got=%0d exp=4", strobe_cyc.size() - base); end
    rsp_ready = 1'b1;
    @(negedge fabric_clk);
    rsp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge fabric_clk);
      if (strobe_cyc.size() - base == 5) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_release got=%0d exp=5", strobe_cyc.size() - base); end
    checks++; if (transaction_data !== 32'd5) begin errors++; $display("FAIL stall_fifth_data got=%h exp=5", transaction_data); end
    min_space = 1000;
    for (int k = base + 1; k < strobe_cyc.size(); k++)
      if (strobe_cyc[k] - strobe_cyc[k-1] < min_space) min_space = strobe_cyc[k] - strobe_cyc[k-1];
    checks++; if (min_space < 4) begin errors++; $display("FAIL issue_spacing got=%0d exp>=4", min_space); end
    for (int i = 0; i < 4; i++) begin
      spi_rd_valid = 1'b1;
      spi_rd_data  = 32'h100 + DW'(i);
      @(negedge fabric_clk);
    end
    spi_rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h100 + DW'(i)) begin
        errors++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, rsp_valid, rsp_data, 32'h100 + DW'(i));
      end
      rsp_ready = 1'b1;
      @(negedge fabric_clk);
    end
    rsp_ready = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b/%b exp=0/0", busy, rsp_valid); end
  endtask

  task automatic test_len_check;
    int base;
    base = strobe_cyc.size();
    gap_cycles = 8'd2;
    push_cmd(6'd0, 32'hDEAD_0000, 32'hFFFF_FFFF);
    push_cmd(6'd40, 32'hBEEF_0000, 32'hFFFF_FFFF);
    repeat (30) @(negedge fabric_clk);
`ifdef SPI_SEQ_LEN_CHECK_EN
    checks++; if (strobe_cyc.size() - base != 0) begin errors++; $display("FAIL len_dropped got=%0d exp=0", strobe_cyc.size() - base); end
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL len_err got=%b exp=1", err_len); end
    checks++; if (transaction_data !== 32'd5) begin errors++; $display("FAIL len_data_hold got=%h exp=5", transaction_data); end
`else
    checks++; if (strobe_cyc.size() - base != 1) begin errors++; $display("FAIL len_strobes got=%0d exp=1", strobe_cyc.size() - base); end
    checks++; if (strobe_cyc.size() > base && strobe_len[base] !== 6'd40) begin errors++; $display("FAIL len_passthru got=%0d exp=40", strobe_len[base]); end
    checks++; if (transaction_data !== 32'hBEEF_0000) begin errors++; $display("FAIL len_data got=%h exp=beef0000", transaction_data); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL len_err got=%b exp=0", err_len); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len_idle got=%b exp=0", busy); end
  endtask

  task automatic test_unexpected;
    spi_rd_valid = 1'b1;
    spi_rd_data  = 32'h0000_0055;
    @(negedge fabric_clk);
    spi_rd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL unexp_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_err got=%b exp=1", err_unexp); end
    repeat (2) @(negedge fabric_clk);
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL unexp_sticky got=%b exp=1", err_unexp); end
  endtask

  task automatic test_full_reset;
    int base;
    int pushes;
    base = strobe_cyc.size();
    gap_cycles = 8'd200;
    pushes = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cmd_ready) break;
      push_cmd(6'd8, DW'(i + 16), 32'hFFFF_FFFF);
      pushes++;
    end
    checks++; if (pushes != 9) begin errors++; $display("FAIL fill_pushes got=%0d exp=9", pushes); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (strobe_cyc.size() - base != 1) begin errors++; $display("FAIL fill_strobes got=%0d exp=1", strobe_cyc.size() - base); end
    repeat (5) @(negedge fabric_clk);
    reset = 1'b1;
    @(negedge fabric_clk);
    reset = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (transaction_data !== '0 || transaction_rw_mask !== '0) begin errors++; $display("FAIL rst_data_mask got=%h/%h exp=0/0", transaction_data, transaction_rw_mask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (err_unexp !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL rst_errs got=%b/%b exp=0/0", err_unexp, err_len); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin errors++; $display("FAIL rst_rsp got=%b/%h exp=0/0", rsp_valid, rsp_data); end
    base = strobe_cyc.size();
    repeat (300) @(negedge fabric_clk);
    checks++; if (strobe_cyc.size() - base != 0) begin errors++; $display("FAIL rst_no_strobe got=%0d exp=0", strobe_cyc.size() - base); end
    checks++; if (busy !== 1'b0 || transaction_length !== '0) begin errors++; $display("FAIL rst_quiet got=%b/%0d exp=0/0", busy, transaction_length); end
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_length   = '0;
    cmd_data     = '0;
    cmd_rw_mask  = '0;
    gap_cycles   = '0;
    spi_rd_valid = 1'b0;
    spi_rd_data  = '0;
    rsp_ready    = 1'b0;
    @(negedge fabric_clk);
    test_reset();
    test_write_issue();
    test_read_credit();
    test_credit_stall();
    test_len_check();
    test_unexpected();
    test_full_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
